// File: rtl/wrr_defs.sv
// wrr_defs: shared definitions for the weighted round-robin scheduler.
// FSM state encoding, default weight width and reset weight value.
package wrr_defs;

  localparam int WEIGHT_BITS_DEF = 4;
  localparam int RST_WEIGHT      = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/wrr_next_sel.sv
// wrr_next_sel: rotating-priority finder, search starts at last+1.
// Ports: eligible (per-queue), last (previous winner) -> found, index.
// WRR_PRIO0_EN: when defined, an eligible queue 0 always wins.
module wrr_next_sel #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int SEL_BITS       = 2
) (
  input  logic [QUEUE_QUANTITY-1:0] eligible,
  input  logic [SEL_BITS-1:0]       last,
  output logic                      found,
  output logic [SEL_BITS-1:0]       index
);

  logic [SEL_BITS-1:0] idx;

  // k runs 1..QUEUE_QUANTITY so 'last' itself is checked last
  always_comb begin
    found = 1'b0;
    index = '0;
    idx   = '0;
    for (int k = 1; k <= QUEUE_QUANTITY; k++) begin
      idx = SEL_BITS'((int'(last) + k) % QUEUE_QUANTITY);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        index = idx;
      end
    end
`ifdef WRR_PRIO0_EN
    if (eligible[0]) begin
      found = 1'b1;
      index = '0;
    end
`else
`endif
  end

endmodule

// File: rtl/wrr_scheduler.sv
// wrr_scheduler: weighted round-robin pop scheduler for N input FIFOs.
// Ports: clk, rst (sync, active-low), enb, buf_empty, dst_almost_full,
//   cfg_weights, cfg_load -> selector, out_enb (pop), busy.
// WRR_PRIO0_EN: queue 0 wins every selection point when eligible.
module wrr_scheduler
  import wrr_defs::*;
#(
  parameter int QUEUE_QUANTITY = 4,
  parameter int SEL_BITS       = 2,
  parameter int WEIGHT_BITS    = WEIGHT_BITS_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
  input  logic                                dst_almost_full,
  input  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] cfg_weights,
  input  logic                                cfg_load,
  output logic [SEL_BITS-1:0]                 selector,
  output logic                                out_enb,
  output logic                                busy
);

  localparam logic [WEIGHT_BITS-1:0] W_ONE = WEIGHT_BITS'(1);
  localparam logic [WEIGHT_BITS-1:0] W_RST = WEIGHT_BITS'(RST_WEIGHT);
  localparam logic [SEL_BITS-1:0]    L_RST = SEL_BITS'(QUEUE_QUANTITY-1);

  state_t                state_q, state_d;
  logic [SEL_BITS-1:0]    sel_q, sel_d;
  logic [SEL_BITS-1:0]    last_q, last_d;
  logic [WEIGHT_BITS-1:0] credit_q, credit_d;
  logic [WEIGHT_BITS-1:0] weight_q [QUEUE_QUANTITY];

  logic [QUEUE_QUANTITY-1:0] eligible;
  logic                      found;
  logic [SEL_BITS-1:0]       found_idx;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < QUEUE_QUANTITY; i++)
      eligible[i] = ~buf_empty[i] & (weight_q[i] != '0);
  end

  wrr_next_sel #(
    .QUEUE_QUANTITY(QUEUE_QUANTITY),
    .SEL_BITS      (SEL_BITS)
  ) u_next_sel (
    .eligible(eligible),
    .last    (last_q),
    .found   (found),
    .index   (found_idx)
  );

  assign selector = sel_q;
  assign busy     = (state_q == ST_SERVE);
  assign out_enb  = enb & (state_q == ST_SERVE)
                  & ~buf_empty[sel_q] & ~dst_almost_full;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    credit_d = credit_q;
    if (enb) begin
      unique case (state_q)
        ST_IDLE: begin
          if (found) begin
            state_d  = ST_SERVE;
            sel_d    = found_idx;
            last_d   = found_idx;
            credit_d = weight_q[found_idx];
          end
        end
        ST_SERVE: begin
          // back-pressure holds everything; otherwise either
          // consume credit or reach a selection point
          if (!dst_almost_full) begin
            if (out_enb && credit_q > W_ONE) begin
              credit_d = credit_q - W_ONE;
            end else if (found) begin
              sel_d    = found_idx;
              last_d   = found_idx;
              credit_d = weight_q[found_idx];
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      last_q   <= L_RST;
      credit_q <= '0;
      for (int i = 0; i < QUEUE_QUANTITY; i++)
        weight_q[i] <= W_RST;
    end else if (enb) begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      credit_q <= credit_d;
      if (cfg_load) begin
        for (int i = 0; i < QUEUE_QUANTITY; i++)
          weight_q[i] <= cfg_weights[i*WEIGHT_BITS +: WEIGHT_BITS];
      end
    end
  end

endmodule

// File: tb/tb_wrr_scheduler.sv
// tb_wrr_scheduler: directed bench for wrr_scheduler.
// Hand-computed selector / out_enb / busy sequences per scenario.
module tb_wrr_scheduler;

`ifdef WRR_PRIO0_EN
  localparam bit P = 1'b1;
`else
  localparam bit P = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        enb;
  logic [3:0]  buf_empty;
  logic        dst_almost_full;
  logic [15:0] cfg_weights;
  logic        cfg_load;
  logic [1:0]  selector;
  logic        out_enb;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  wrr_scheduler #(
    .QUEUE_QUANTITY(4),
    .SEL_BITS      (2),
    .WEIGHT_BITS   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enb            (enb),
    .buf_empty      (buf_empty),
    .dst_almost_full(dst_almost_full),
    .cfg_weights    (cfg_weights),
    .cfg_load       (cfg_load),
    .selector       (selector),
    .out_enb        (out_enb),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_load(input logic [15:0] w);
    rst             = 1'b0;
    enb             = 1'b1;
    cfg_load        = 1'b0;
    buf_empty       = 4'hF;
    dst_almost_full = 1'b0;
    tick();
    rst         = 1'b1;
    cfg_weights = w;
    cfg_load    = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  int s2 [10] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1};
  int s3 [6]  = '{1, 2, 2, 3, 3, 1};
  int s9 [4]  = '{0, 2, 3, 0};

  initial begin
    rst             = 1'b0;
    enb             = 1'b1;
    buf_empty       = 4'h0;
    dst_almost_full = 1'b0;
    cfg_weights     = 16'h0;
    cfg_load        = 1'b0;

    // plain round-robin out of reset
    tick();
    tick();
    chk("rst_sel", selector, 0);
    chk("rst_busy", busy, 0);
    chk("rst_oe", out_enb, 0);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_sel", selector, P ? 0 : k % 4);
      chk("rr_oe", out_enb, 1);
    end

    // q0 weight 3, others 1
    reset_load(16'h1113);
    buf_empty = 4'h0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("w3_sel", selector, P ? 0 : s2[k]);
    end

    // weights 2, q0 drains after one pop
    reset_load(16'h2222);
    buf_empty = 4'h0;
    tick();
    chk("drn_sel0", selector, 0);
    chk("drn_oe0", out_enb, 1);
    tick();
    chk("drn_sel1", selector, 0);
    buf_empty = 4'b0001;
    #1;
    chk("drn_oe_empty", out_enb, 0);
    tick();
    chk("drn_sel_q1", selector, 1);
    chk("drn_oe_q1", out_enb, 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("drn_seq", selector, s3[k]);
    end

    // back-pressure mid-burst, 2 credits left on q0
    reset_load(16'h1113);
    buf_empty = 4'h0;
    tick();
    tick();
    dst_almost_full = 1'b1;
    #1;
    chk("bp_oe", out_enb, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_sel", selector, 0);
      chk("bp_oe_hold", out_enb, 0);
      chk("bp_busy", busy, 1);
    end
    dst_almost_full = 1'b0;
    #1;
    chk("bp_oe_rel", out_enb, 1);
    tick();
    chk("bp_pop2", selector, 0);
    tick();
    chk("bp_next", selector, P ? 0 : 1);

    // all empty, then only q2 fills
    reset_load(16'h1111);
    tick();
    chk("emp_busy", busy, 0);
    chk("emp_oe", out_enb, 0);
    buf_empty = 4'b1011;
    tick();
    chk("q2_busy", busy, 1);
    chk("q2_sel", selector, 2);
    chk("q2_oe", out_enb, 1);

    // reset in the middle of a q1 burst
    reset_load(16'h3333);
    buf_empty = 4'b1101;
    tick();
    tick();
    chk("mid_sel", selector, 1);
    rst = 1'b0;
    tick();
    chk("mrst_sel", selector, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_oe", out_enb, 0);
    rst       = 1'b1;
    buf_empty = 4'h0;
    tick();
    chk("mrst_q0", selector, 0);
    tick();
    chk("mrst_w1", selector, P ? 0 : 1);

    // enable low freezes a burst
    reset_load(16'h1113);
    buf_empty = 4'h0;
    tick();
    enb = 1'b0;
    #1;
    chk("enb_oe", out_enb, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("enb_sel", selector, 0);
      chk("enb_busy", busy, 1);
    end
    enb = 1'b1;
    tick();
    chk("enb_r1", selector, 0);
    tick();
    chk("enb_r2", selector, 0);
    tick();
    chk("enb_r3", selector, P ? 0 : 1);

    // all weights zero: never leaves IDLE
    reset_load(16'h0000);
    buf_empty = 4'h0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("w0_busy", busy, 0);
      chk("w0_oe", out_enb, 0);
    end

    // q1 weight 0 is skipped
    reset_load(16'h1101);
    buf_empty = 4'h0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("skip_sel", selector, P ? 0 : s9[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wrr_scheduler.md
Name: wrr_scheduler

Overview:
- Weighted round-robin scheduler that shares one output port between QUEUE_QUANTITY input FIFOs.
- Drives the output mux selector and the pop strobe of the selected FIFO.
- Each queue gets up to its configured weight of consecutive pops per turn.
- Honours downstream back-pressure; sits between the input queues and the output FIFO of the switch datapath.

Parameters:
- QUEUE_QUANTITY, 4, number of input queues.
- SEL_BITS, 2, selector width; must satisfy 2**SEL_BITS >= QUEUE_QUANTITY.
- WEIGHT_BITS, 4, width of each per-queue weight; weight range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- enb  input  1  block enable; when low, state is frozen and out_enb is 0.
- buf_empty  input  QUEUE_QUANTITY  per-queue empty flags; bit i high means queue i is empty.
- dst_almost_full  input  1  downstream back-pressure; when high, no pop is issued.
- cfg_weights  input  QUEUE_QUANTITY*WEIGHT_BITS  weight of queue i in bits [i*WEIGHT_BITS +: WEIGHT_BITS].
- cfg_load  input  1  latches cfg_weights into shadow weight registers.
- selector  output  SEL_BITS  registered index of the queue being served.
- out_enb  output  1  combinational pop strobe for queue[selector].
- busy  output  1  registered; high in state SERVE.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, selector=0, credit=0, last=QUEUE_QUANTITY-1, busy=0.
  - All shadow weights=1, so the block behaves as plain round-robin.
  - Reset overrides cfg_load and enb, and aborts a burst mid-operation with no pending pop.
- Eligibility: queue i is eligible when buf_empty[i]==0 and weight[i]!=0.
- Next-queue search: rotating priority starting at last+1, wrapping modulo QUEUE_QUANTITY. The queue equal to last is checked last, so a single eligible queue is reselected.
- Pop strobe: out_enb = enb & (state==SERVE) & ~buf_empty[selector] & ~dst_almost_full.
  - The pop happens in the same cycle; the FIFO updates its empty flag at the next edge.
- IDLE:
  - If enb and any queue is eligible: selector<=found, last<=found, credit<=weight[found], state<=SERVE.
  - Otherwise remain in IDLE.
- SERVE, each edge with enb=1:
  - dst_almost_full=1: hold. No change to selector or credit.
  - Pop with credit>1: credit<=credit-1 and remain on the same queue.
  - Pop with credit==1, or buf_empty[selector]==1 (no pop): selection point. Run the search; if a queue is found, load it with credit<=its weight; if none, state<=IDLE.
  - In the same cycle, a credit-expiry and a new empty flag count as one selection point.
- enb=0: all registers hold and out_enb=0, including during a burst; the block resumes exactly where it stopped.
- cfg_load: shadow weights update at the edge. The current credit is unaffected; new weights apply from the next credit load.
  - A weight written as 0 excludes that queue from the next selection point onward.
  - A queue currently being served with credit>0 finishes its current credit.
- All weights 0: the block stays in IDLE permanently and out_enb is 0.
- Arithmetic: credit is WEIGHT_BITS wide and is never decremented below 1 or reloaded with 0.

Optional Feature:
- Macro: WRR_PRIO0_EN.
- Defined: at every selection point and on IDLE exit, queue 0 is chosen whenever it is eligible, ahead of the rotating search. Bursts in progress are not pre-empted. Queue 0 may starve the other queues; this is accepted.
- Undefined: pure weighted round-robin as specified above.

Decomposition:
- Shared package wrr_defs:
  - state encoding localparams ST_IDLE=0, ST_SERVE=1;
  - default WEIGHT_BITS;
  - reset weight value 1.
- Sub-module wrr_next_sel: combinational rotating-priority finder.
  - Inputs: eligible vector, last.
  - Outputs: found, index.
  - Instantiated once; it also absorbs the WRR_PRIO0_EN override.

Test Plan:
- Reset, weights default, buf_empty=4'b0000, dst_almost_full=0 → after rst goes high: selector sequence 0,1,2,3,0 with one pop each; out_enb continuously 1.
- cfg_load with weights {q3=1,q2=1,q1=1,q0=3}, all queues non-empty → three pops of q0, then one pop each of q1, q2, q3, repeating.
- Weights all 2, q0 holds exactly 1 word, others full → one pop of q0; buf_empty[0] rises; next edge selector=1 with credit 2; q0 is skipped until refilled.
- dst_almost_full held high for 5 cycles mid-burst (q0, credit 2 remaining) → out_enb=0 and selector/credit frozen for 5 cycles; then 2 more q0 pops.
- buf_empty=4'b1111 → state IDLE, busy=0, out_enb=0. Deassert buf_empty[2] only → busy=1 next edge, selector=2.
- Assert rst=0 in the middle of a q1 burst → next edge selector=0, busy=0, weights back to 1. With WRR_PRIO0_EN defined and q0, q1 non-empty → q0 is served at every selection point.
